// File: rtl/acc_wb_stage.sv
// rtl/acc_wb_stage.sv - accumulator writeback stage with BNEZ resolve and SPI sequencing
// Optional SPI wait timeout: define ACC_WB_SPI_TIMEOUT_EN.
module acc_wb_stage #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [2:0]        unit_sel_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [PC_W-1:0]   target_in,
  output logic              spi_start_out,
  output logic [DATA_W-1:0] spi_tx_out,
  input  logic              spi_done_in,
  input  logic [DATA_W-1:0] spi_rx_in,
  output logic [DATA_W-1:0] acc_out,
  output logic              zero_out,
  output logic              branch_taken_out,
  output logic [PC_W-1:0]   branch_target_out,
`ifdef ACC_WB_SPI_TIMEOUT_EN
  output logic              spi_err_out,
`endif
  output logic              retire_out
);

  localparam logic [2:0] UNIT_SPI  = 3'b001;
  localparam logic [2:0] UNIT_BNEZ = 3'b111;

  typedef enum logic {S_IDLE, S_SPI_WAIT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [PC_W-1:0]   tgt_q, tgt_d;
  logic              start_q, start_d;
  logic              ret_q, ret_d;
  logic              br_q, br_d;
  logic              accept;
  logic              timeout;

  assign accept = valid_in && (state_q == S_IDLE);

`ifdef ACC_WB_SPI_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // A done pulse in the expiry cycle takes priority over the timeout.
  assign timeout = (state_q == S_SPI_WAIT) && !spi_done_in && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (accept)
      cnt_d = 8'd0;
    else if (state_q == S_SPI_WAIT)
      cnt_d = cnt_q + 8'd1;
    err_d = err_q | timeout;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign spi_err_out = err_q;
`else
  assign timeout = 1'b0;

  // The wait limit has no effect when the timeout counter is not built.
  if (TIMEOUT_CYC > 255) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept && unit_sel_in == UNIT_SPI) state_d = S_SPI_WAIT;
      S_SPI_WAIT: if (spi_done_in || timeout) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    tx_d    = tx_q;
    tgt_d   = tgt_q;
    start_d = 1'b0;
    ret_d   = 1'b0;
    br_d    = 1'b0;
    if (accept) begin
      case (unit_sel_in)
        UNIT_SPI: begin
          tx_d    = alu_res_in;
          start_d = 1'b1;
        end
        UNIT_BNEZ: begin
          ret_d = 1'b1;
          if (acc_q != '0) begin
            br_d  = 1'b1;
            tgt_d = target_in;
          end
        end
        default: begin
          acc_d = alu_res_in;
          ret_d = 1'b1;
        end
      endcase
    end else if (state_q == S_SPI_WAIT) begin
      if (spi_done_in) begin
        acc_d = spi_rx_in;
        ret_d = 1'b1;
      end else if (timeout) begin
        acc_d = '1;
        ret_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_q   <= '0;
      tx_q    <= '0;
      tgt_q   <= '0;
      start_q <= 1'b0;
      ret_q   <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      tx_q    <= tx_d;
      tgt_q   <= tgt_d;
      start_q <= start_d;
      ret_q   <= ret_d;
      br_q    <= br_d;
    end
  end

  assign ready_out         = (state_q == S_IDLE);
  assign acc_out           = acc_q;
  assign zero_out          = (acc_q == '0);
  assign spi_tx_out        = tx_q;
  assign spi_start_out     = start_q;
  assign retire_out        = ret_q;
  assign branch_taken_out  = br_q;
  assign branch_target_out = tgt_q;

endmodule

// File: tb/tb_acc_wb_stage.sv
// tb/tb_acc_wb_stage.sv - directed and randomized checks of acc_wb_stage against a reference model
module tb_acc_wb_stage;
  localparam int DW = 8;
  localparam int PW = 8;
  localparam int TO = 4;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic [2:0]    unit_sel_in = 3'd0;
  logic [DW-1:0] alu_res_in = '0;
  logic [PW-1:0] target_in = '0;
  logic          spi_start_out;
  logic [DW-1:0] spi_tx_out;
  logic          spi_done_in = 1'b0;
  logic [DW-1:0] spi_rx_in = '0;
  logic [DW-1:0] acc_out;
  logic          zero_out;
  logic          branch_taken_out;
  logic [PW-1:0] branch_target_out;
  logic          retire_out;
`ifdef ACC_WB_SPI_TIMEOUT_EN
  logic          spi_err_out;
`endif

  acc_wb_stage #(.DATA_W(DW), .PC_W(PW), .TIMEOUT_CYC(TO)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(ready_out),
    .unit_sel_in(unit_sel_in), .alu_res_in(alu_res_in), .target_in(target_in),
    .spi_start_out(spi_start_out), .spi_tx_out(spi_tx_out), .spi_done_in(spi_done_in),
    .spi_rx_in(spi_rx_in), .acc_out(acc_out), .zero_out(zero_out),
    .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out),
`ifdef ACC_WB_SPI_TIMEOUT_EN
    .spi_err_out(spi_err_out),
`endif
    .retire_out(retire_out)
  );

  always #5 clk_in = ~clk_in;

  int    errors = 0;
  int    checks = 0;
  string ph = "init";

  // Reference model state: what the architecture should hold, not how the RTL holds it
  logic [7:0] m_acc, m_tx, m_tgt;
  logic       m_busy, m_err;
  int         m_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", ph, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_tx = 0; m_tgt = 0; m_busy = 0; m_err = 0; m_wait = 0;
  endtask

  task automatic check_state(input logic e_ret, input logic e_br, input logic e_start);
    chk("acc", acc_out, m_acc);
    chk("zero", zero_out, m_acc == 0);
    chk("ready", ready_out, !m_busy);
    chk("retire", retire_out, e_ret);
    chk("branch", branch_taken_out, e_br);
    chk("target", branch_target_out, m_tgt);
    chk("start", spi_start_out, e_start);
    chk("tx", spi_tx_out, m_tx);
`ifdef ACC_WB_SPI_TIMEOUT_EN
    chk("err", spi_err_out, m_err);
`endif
  endtask

  task automatic step(input logic v, input logic [2:0] op, input logic [7:0] res,
                      input logic [7:0] tgt, input logic done, input logic [7:0] rx);
    logic e_ret, e_br, e_start;
    valid_in = v; unit_sel_in = op; alu_res_in = res; target_in = tgt;
    spi_done_in = done; spi_rx_in = rx;
    e_ret = 0; e_br = 0; e_start = 0;
    if (!m_busy) begin
      if (v) begin
        if (op == 3'd1) begin
          m_tx = res; m_busy = 1; m_wait = 0; e_start = 1;
        end else if (op == 3'd7) begin
          e_ret = 1;
          if (m_acc != 0) begin e_br = 1; m_tgt = tgt; end
        end else begin
          m_acc = res; e_ret = 1;
        end
      end
    end else begin
      if (done) begin
        m_acc = rx; e_ret = 1; m_busy = 0;
      end
`ifdef ACC_WB_SPI_TIMEOUT_EN
      else if (m_wait == TO - 1) begin
        m_acc = 8'hFF; e_ret = 1; m_busy = 0; m_err = 1;
      end else m_wait++;
`endif
    end
    @(posedge clk_in); #1;
    check_state(e_ret, e_br, e_start);
  endtask

  initial begin
    model_reset();
    ph = "reset";
    #2;
    check_state(0, 0, 0);
    #1 rst_n_in = 1'b1;

    ph = "alu000";
    step(1, 3'd0, 8'h3C, 8'h00, 0, 8'h00);
    step(0, 3'd0, 8'h00, 8'h00, 0, 8'h00);

    ph = "bnez_taken";
    step(1, 3'd0, 8'h01, 8'h00, 0, 8'h00);
    step(1, 3'd7, 8'h00, 8'h42, 0, 8'h00);
    ph = "bnez_not_taken";
    step(1, 3'd0, 8'h00, 8'h00, 0, 8'h00);
    step(1, 3'd7, 8'h00, 8'h99, 0, 8'h00);

    ph = "spi";
    step(1, 3'd1, 8'hA5, 8'h00, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(1, 3'd0, 8'h77, 8'h00, 0, 8'h00);
    step(0, 3'd0, 8'h00, 8'h00, 1, 8'h5A);
    step(0, 3'd0, 8'h00, 8'h00, 0, 8'h00);

    ph = "back2back";
    for (int i = 1; i <= 5; i++) step(1, 3'd2 + 3'(i % 5), 8'(i), 8'h00, 0, 8'h00);
    ph = "stray_done";
    step(0, 3'd0, 8'h00, 8'h00, 1, 8'hEE);

    ph = "spi_zero_latency";
    step(1, 3'd1, 8'h11, 8'h00, 0, 8'h00);
    step(0, 3'd0, 8'h00, 8'h00, 1, 8'h22);
    step(0, 3'd0, 8'h00, 8'h00, 0, 8'h00);

    ph = "reset_mid_spi";
    step(1, 3'd1, 8'h33, 8'h00, 0, 8'h00);
    step(0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
    #2 rst_n_in = 1'b0;
    #1;
    model_reset();
    check_state(0, 0, 0);
    #1 rst_n_in = 1'b1;
    step(0, 3'd0, 8'h00, 8'h00, 1, 8'h77);
    step(0, 3'd0, 8'h00, 8'h00, 0, 8'h00);

`ifdef ACC_WB_SPI_TIMEOUT_EN
    ph = "timeout";
    step(1, 3'd1, 8'h44, 8'h00, 0, 8'h00);
    for (int i = 0; i < TO; i++) step(0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
    chk("timeout_acc", acc_out, 8'hFF);
    ph = "timeout_done_wins";
    @(negedge clk_in) rst_n_in = 1'b0;
    model_reset();
    @(negedge clk_in) rst_n_in = 1'b1;
    step(1, 3'd1, 8'h55, 8'h00, 0, 8'h00);
    for (int i = 0; i < TO - 1; i++) step(0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
    step(0, 3'd0, 8'h00, 8'h00, 1, 8'h66);
    chk("done_wins_acc", acc_out, 8'h66);
`endif

    ph = "random";
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
           8'($urandom), $urandom_range(0, 2) == 0, 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
